// File: rtl/alarm_timer_scheduler.sv
// Interval sequencer for the car-alarm one-second divider: holds four programmable
// intervals, restarts the divider and counts the selected interval down to expiry.
// Optional feature: define TIMER_PAUSE_EN to add a `pause` input that freezes the countdown.
module alarm_timer_scheduler #(
    parameter int VAL_W = 4,
    parameter int DEF0  = 6,
    parameter int DEF1  = 8,
    parameter int DEF2  = 15,
    parameter int DEF3  = 10
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             one_hz_enable,
    input  logic             start,
    input  logic [1:0]       interval_sel,
    input  logic             abort,
    input  logic             prog_write,
    input  logic [1:0]       prog_sel,
    input  logic [VAL_W-1:0] prog_value,
`ifdef TIMER_PAUSE_EN
    input  logic             pause,
`endif
    output logic             start_timer,
    output logic             expired,
    output logic             busy,
    output logic [VAL_W-1:0] remaining,
    output logic [1:0]       active_sel
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COUNT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [VAL_W-1:0] r_intv [4];
    logic             r_start_timer;
    logic             r_expired;
    logic             r_busy;
    logic [VAL_W-1:0] r_remaining;
    logic [1:0]       r_active_sel;

    logic             w_tick;
    logic             w_resume;

`ifdef TIMER_PAUSE_EN
    logic r_pause_q;

    assign w_tick   = one_hz_enable & ~pause;
    assign w_resume = r_pause_q & ~pause;

    always_ff @(posedge clock) begin
        if (!reset_n) r_pause_q <= 1'b0;
        else          r_pause_q <= pause;
    end
`else
    assign w_tick   = one_hz_enable;
    assign w_resume = 1'b0;
`endif

    // NOTE: this small register file is reset on purpose -- the defaults are real
    // configuration values, and reset must discard anything programmed since.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_intv[0] <= VAL_W'(DEF0);
            r_intv[1] <= VAL_W'(DEF1);
            r_intv[2] <= VAL_W'(DEF2);
            r_intv[3] <= VAL_W'(DEF3);
        end else if (prog_write) begin
            r_intv[prog_sel] <= prog_value;
        end
    end

    // NOTE: all state is updated with non-blocking assignments, so every branch below
    // reads the pre-edge values of r_state, r_remaining and r_intv.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_start_timer <= 1'b0;
            r_expired     <= 1'b0;
            r_busy        <= 1'b0;
            r_remaining   <= '0;
            r_active_sel  <= 2'd0;
        end else begin
            // Pulse outputs default low; only the branches that raise them override.
            r_start_timer <= 1'b0;
            r_expired     <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_state       <= S_LOAD;
                        r_active_sel  <= interval_sel;
                        r_start_timer <= 1'b1;
                        r_busy        <= 1'b1;
                    end
                end

                S_LOAD: begin
                    if (abort) begin
                        r_state     <= S_IDLE;
                        r_remaining <= '0;
                        r_busy      <= 1'b0;
                    end else if (start) begin
                        r_state       <= S_LOAD;
                        r_active_sel  <= interval_sel;
                        r_start_timer <= 1'b1;
                    end else begin
                        // Any tick here is dropped: the divider restarts from zero.
                        r_remaining <= r_intv[r_active_sel];
                        if (r_intv[r_active_sel] == '0) begin
                            r_state   <= S_DONE;
                            r_expired <= 1'b1;
                        end else begin
                            r_state <= S_COUNT;
                        end
                    end
                end

                S_COUNT: begin
                    if (abort) begin
                        r_state     <= S_IDLE;
                        r_remaining <= '0;
                        r_busy      <= 1'b0;
                    end else if (start) begin
                        r_state       <= S_LOAD;
                        r_active_sel  <= interval_sel;
                        r_start_timer <= 1'b1;
                    end else begin
                        if (w_resume) begin
                            r_start_timer <= 1'b1;
                        end
                        if (w_tick && r_remaining != '0) begin
                            r_remaining <= r_remaining - 1'b1;
                            if (r_remaining == VAL_W'(1)) begin
                                r_state   <= S_DONE;
                                r_expired <= 1'b1;
                            end
                        end
                    end
                end

                S_DONE: begin
                    if (start && !abort) begin
                        r_state       <= S_LOAD;
                        r_active_sel  <= interval_sel;
                        r_start_timer <= 1'b1;
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_remaining <= '0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign start_timer = r_start_timer;
    assign expired     = r_expired;
    assign busy        = r_busy;
    assign remaining   = r_remaining;
    assign active_sel  = r_active_sel;

endmodule

// File: tb/tb_alarm_timer_scheduler.sv
// Self-checking bench for alarm_timer_scheduler: directed table, reset corner cases,
// and randomized traffic compared against a behavioural countdown model.
module tb_alarm_timer_scheduler;

    logic       clock;
    logic       reset_n;
    logic       one_hz_enable;
    logic       start;
    logic [1:0] interval_sel;
    logic       abort;
    logic       prog_write;
    logic [1:0] prog_sel;
    logic [3:0] prog_value;
`ifdef TIMER_PAUSE_EN
    logic       pause;
`endif
    logic       start_timer;
    logic       expired;
    logic       busy;
    logic [3:0] remaining;
    logic [1:0] active_sel;

    alarm_timer_scheduler dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .one_hz_enable (one_hz_enable),
        .start         (start),
        .interval_sel  (interval_sel),
        .abort         (abort),
        .prog_write    (prog_write),
        .prog_sel      (prog_sel),
        .prog_value    (prog_value),
`ifdef TIMER_PAUSE_EN
        .pause         (pause),
`endif
        .start_timer   (start_timer),
        .expired       (expired),
        .busy          (busy),
        .remaining     (remaining),
        .active_sel    (active_sel)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the timer is doing (loading, counting, expiring),
    // seconds left and the interval table, updated once per clock edge.
    bit m_load, m_count, m_done, m_st, m_exp;
    int m_rem, m_sel;
    int m_prog [4];

    task automatic m_edge(input bit rn, input bit st, input bit ab, input bit tk,
                          input logic [1:0] sel, input bit pw, input logic [1:0] ps,
                          input logic [3:0] pv);
        int load_val;
        load_val = m_prog[m_sel];
        if (!rn) begin
            m_load = 0; m_count = 0; m_done = 0; m_st = 0; m_exp = 0;
            m_rem = 0; m_sel = 0;
            m_prog[0] = 6; m_prog[1] = 8; m_prog[2] = 15; m_prog[3] = 10;
            return;
        end
        m_st  = 0;
        m_exp = 0;
        if (ab) begin
            if (m_load || m_count) m_rem = 0;
            m_load = 0; m_count = 0; m_done = 0;
        end else if (st) begin
            m_load = 1; m_count = 0; m_done = 0; m_st = 1;
            m_sel  = int'(sel);
        end else if (m_load) begin
            m_load = 0;
            m_rem  = load_val;
            if (m_rem == 0) begin m_done = 1; m_exp = 1; end
            else m_count = 1;
        end else if (m_count) begin
            if (tk && m_rem > 0) m_rem = m_rem - 1;
            if (m_rem == 0) begin m_count = 0; m_done = 1; m_exp = 1; end
        end else begin
            m_done = 0;
        end
        if (pw) m_prog[int'(ps)] = int'(pv);
    endtask

    task automatic cyc(input bit rn, input bit st, input bit ab, input bit tk,
                       input logic [1:0] sel, input bit pw, input logic [1:0] ps,
                       input logic [3:0] pv);
        reset_n = rn; start = st; abort = ab; one_hz_enable = tk;
        interval_sel = sel; prog_write = pw; prog_sel = ps; prog_value = pv;
        @(posedge clock);
        m_edge(rn, st, ab, tk, sel, pw, ps, pv);
        #1;
        reset_n = 1'b1; start = 1'b0; abort = 1'b0; one_hz_enable = 1'b0;
        prog_write = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".start_timer"}, 32'(start_timer), 32'(m_st));
        check({tag, ".expired"},     32'(expired),     32'(m_exp));
        check({tag, ".busy"},        32'(busy),        32'(m_load | m_count | m_done));
        check({tag, ".remaining"},   32'(remaining),   m_rem);
        check({tag, ".active_sel"},  32'(active_sel),  m_sel);
    endtask

    typedef struct {
        bit         st, ab, tk;
        logic [1:0] sel;
        bit         pw;
        logic [1:0] ps;
        logic [3:0] pv;
        bit         e_st, e_exp, e_busy;
        int         e_rem, e_asel;
    } vec_t;

    function automatic vec_t mk(int st, int ab, int tk, int sel, int pw, int ps, int pv,
                                int est, int eexp, int ebusy, int erem, int easel);
        vec_t v;
        v.st = (st != 0); v.ab = (ab != 0); v.tk = (tk != 0); v.sel = 2'(sel);
        v.pw = (pw != 0); v.ps = 2'(ps); v.pv = 4'(pv);
        v.e_st = (est != 0); v.e_exp = (eexp != 0); v.e_busy = (ebusy != 0);
        v.e_rem = erem; v.e_asel = easel;
        return v;
    endfunction

    vec_t tbl[$];
    int   n_exp_pulses;
    int   n_st_pulses;

    initial begin
        reset_n = 1'b0; start = 1'b0; abort = 1'b0; one_hz_enable = 1'b0;
        interval_sel = 2'd0; prog_write = 1'b0; prog_sel = 2'd0; prog_value = 4'd0;
`ifdef TIMER_PAUSE_EN
        pause = 1'b0;
`endif

        //  st ab tk sel pw ps pv | st exp busy rem asel
        tbl.push_back(mk(1,0,0,0, 0,0,0,  1,0,1,0,0));  // start sel0
        tbl.push_back(mk(0,0,1,0, 1,1,3,  0,0,1,6,0));  // tick in LOAD dropped; write sel1=3
        tbl.push_back(mk(0,0,1,0, 0,0,0,  0,0,1,5,0));
        tbl.push_back(mk(0,0,1,0, 0,0,0,  0,0,1,4,0));
        tbl.push_back(mk(1,0,0,0, 0,0,0,  1,0,1,4,0));  // restart at 4
        tbl.push_back(mk(0,0,0,0, 0,0,0,  0,0,1,6,0));
        tbl.push_back(mk(0,0,1,0, 0,0,0,  0,0,1,5,0));
        tbl.push_back(mk(0,1,0,0, 0,0,0,  0,0,0,0,0));  // abort
        tbl.push_back(mk(1,1,0,3, 0,0,0,  0,0,0,0,0));  // start+abort in IDLE
        tbl.push_back(mk(0,0,1,0, 0,0,0,  0,0,0,0,0));  // tick in IDLE
        tbl.push_back(mk(1,0,0,1, 0,0,0,  1,0,1,0,1));  // start sel1 (now 3)
        tbl.push_back(mk(0,0,0,0, 0,0,0,  0,0,1,3,1));
        tbl.push_back(mk(0,0,1,0, 0,0,0,  0,0,1,2,1));
        tbl.push_back(mk(0,0,1,0, 0,0,0,  0,0,1,1,1));
        tbl.push_back(mk(0,0,1,0, 0,0,0,  0,1,1,0,1));  // expire
        tbl.push_back(mk(0,0,1,0, 0,0,0,  0,0,0,0,1));  // tick in DONE ignored
        tbl.push_back(mk(0,0,0,0, 1,3,0,  0,0,0,0,1));  // program sel3=0
        tbl.push_back(mk(1,0,0,3, 0,0,0,  1,0,1,0,3));  // zero interval
        tbl.push_back(mk(0,0,0,0, 0,0,0,  0,1,1,0,3));  // expired at N+2
        tbl.push_back(mk(0,0,0,0, 0,0,0,  0,0,0,0,3));
        tbl.push_back(mk(1,0,0,0, 0,0,0,  1,0,1,0,0));  // start sel0
        tbl.push_back(mk(0,0,0,0, 0,0,0,  0,0,1,6,0));
        tbl.push_back(mk(0,0,1,0, 1,0,2,  0,0,1,5,0));  // write sel0 mid-count
        tbl.push_back(mk(0,0,1,0, 0,0,0,  0,0,1,4,0));
        tbl.push_back(mk(0,0,1,0, 0,0,0,  0,0,1,3,0));
        tbl.push_back(mk(0,0,1,0, 0,0,0,  0,0,1,2,0));
        tbl.push_back(mk(0,0,1,0, 0,0,0,  0,0,1,1,0));
        tbl.push_back(mk(0,0,1,0, 0,0,0,  0,1,1,0,0));  // still 6 ticks
        tbl.push_back(mk(1,0,0,0, 0,0,0,  1,0,1,0,0));  // start in DONE honoured
        tbl.push_back(mk(0,0,0,0, 0,0,0,  0,0,1,2,0));  // new value 2
        tbl.push_back(mk(0,1,0,0, 0,0,0,  0,0,0,0,0));
        tbl.push_back(mk(1,0,0,3, 0,0,0,  1,0,1,0,3));
        tbl.push_back(mk(0,0,0,0, 0,0,0,  0,1,1,0,3));
        tbl.push_back(mk(0,1,0,0, 0,0,0,  0,0,0,0,3));  // abort in DONE

        // Reset defaults and a full sel=2 countdown.
        cyc(0, 0, 0, 0, 2'd0, 0, 2'd0, 4'd0);
        cyc(0, 0, 0, 0, 2'd0, 0, 2'd0, 4'd0);
        check("rst.start_timer", 32'(start_timer), 0);
        check("rst.expired",     32'(expired),     0);
        check("rst.busy",        32'(busy),        0);
        check("rst.remaining",   32'(remaining),   0);
        check("rst.active_sel",  32'(active_sel),  0);

        n_exp_pulses = 0;
        n_st_pulses  = 0;
        cyc(1, 1, 0, 0, 2'd2, 0, 2'd0, 4'd0);
        check("def.load_pulse", 32'(start_timer), 1);
        check("def.active_sel", 32'(active_sel),  2);
        cyc(1, 0, 0, 0, 2'd0, 0, 2'd0, 4'd0);
        check("def.loaded", 32'(remaining), 15);
        for (int i = 1; i <= 15; i++) begin
            cyc(1, 0, 0, 1, 2'd0, 0, 2'd0, 4'd0);
            n_exp_pulses += int'(expired);
            n_st_pulses  += int'(start_timer);
            check("def.remaining", 32'(remaining), 32'(15 - i));
            check("def.expired",   32'(expired),   (i == 15) ? 1 : 0);
            if (i < 15) begin
                cyc(1, 0, 0, 0, 2'd0, 0, 2'd0, 4'd0);
                n_exp_pulses += int'(expired);
                n_st_pulses  += int'(start_timer);
            end
        end
        cyc(1, 0, 0, 0, 2'd0, 0, 2'd0, 4'd0);
        n_exp_pulses += int'(expired);
        check("def.busy_low",       32'(busy),   0);
        check("def.expired_once",   n_exp_pulses, 1);
        check("def.no_extra_start", n_st_pulses,  0);

        // Directed table.
        foreach (tbl[k]) begin
            cyc(1, tbl[k].st, tbl[k].ab, tbl[k].tk, tbl[k].sel, tbl[k].pw, tbl[k].ps, tbl[k].pv);
            check($sformatf("tbl%0d.start_timer", k), 32'(start_timer), 32'(tbl[k].e_st));
            check($sformatf("tbl%0d.expired", k),     32'(expired),     32'(tbl[k].e_exp));
            check($sformatf("tbl%0d.busy", k),        32'(busy),        32'(tbl[k].e_busy));
            check($sformatf("tbl%0d.remaining", k),   32'(remaining),   tbl[k].e_rem);
            check($sformatf("tbl%0d.active_sel", k),  32'(active_sel),  tbl[k].e_asel);
        end

        // Reset mid-countdown: outputs clear, no expiry, defaults restored.
        cyc(1, 1, 0, 0, 2'd2, 0, 2'd0, 4'd0);
        cyc(1, 0, 0, 0, 2'd0, 0, 2'd0, 4'd0);
        cyc(1, 0, 0, 1, 2'd0, 0, 2'd0, 4'd0);
        check("mid.remaining", 32'(remaining), 14);
        cyc(0, 0, 0, 1, 2'd0, 0, 2'd0, 4'd0);
        check("mid.start_timer", 32'(start_timer), 0);
        check("mid.expired",     32'(expired),     0);
        check("mid.busy",        32'(busy),        0);
        check("mid.remaining0",  32'(remaining),   0);
        check("mid.active_sel",  32'(active_sel),  0);
        cyc(1, 0, 0, 1, 2'd0, 0, 2'd0, 4'd0);
        check("mid.no_expire", 32'(expired), 0);
        cyc(1, 1, 0, 0, 2'd3, 0, 2'd0, 4'd0);
        cyc(1, 0, 0, 0, 2'd0, 0, 2'd0, 4'd0);
        check("mid.default3_restored", 32'(remaining), 10);
        cyc(1, 0, 1, 0, 2'd0, 0, 2'd0, 4'd0);
        check_model("mid.drain");

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bit rn, st, ab, tk, pw;
            rn = !($urandom_range(0, 999) < 3);
            st = ($urandom_range(0, 99) < 6);
            ab = ($urandom_range(0, 99) < 3);
            tk = ($urandom_range(0, 99) < 35);
            pw = ($urandom_range(0, 99) < 5);
            cyc(rn, st, ab, tk, 2'($urandom_range(0, 3)), pw,
                2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
            check_model($sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
